lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Memory-access stage directly downstream of the ALU: takes the ALU result as the
//  effective address and performs the load/store over a req/gnt/rvalid data bus,
//  replacing ad-hoc DPI reads in the ALU. It aligns and sign/zero-extends load data,
//  builds byte strobes for stores, and hands results to writeback with valid/ready.
// PARAMETERS
//  ADDR_W  64  effective address width (ALU result width)
//  DATA_W  64  data bus width; byte lanes = DATA_W/8 = 8
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  ex_valid     in   1   ALU stage presents a memory op
//  ex_ready     out  1   stage can accept (IDLE only)
//  ex_addr      in   64  effective address = alu_res
//  ex_wdata     in   64  store data (rs2), low bytes significant
//  ex_mem_op    in   4   {store, unsigned, size[1:0]}; size 0=B 1=H 2=W 3=D
//  ex_rd        in   5   load destination register
//  dmem_req     out  1   bus request, held until dmem_gnt
//  dmem_gnt     in   1   bus accepts request this cycle
//  dmem_we      out  1   1=store
//  dmem_addr    out  64  ex_addr with [2:0] cleared
//  dmem_wdata   out  64  store data shifted into lane position
//  dmem_wstrb   out  8   byte enables (0 for loads)
//  dmem_rvalid  in   1   read data valid
//  dmem_rdata   in   64  aligned 8-byte read data
//  wb_valid     out  1   result for writeback
//  wb_ready     in   1   writeback accepts
//  wb_rdata     out  64  extended load data (0 for store/misaligned)
//  wb_rd        out  5   dest reg; 0 for stores and misaligned ops
//  wb_misalign  out  1   op was misaligned, no bus access made
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; every output 0 except ex_ready=1; an in-flight
//    bus transaction is abandoned; a subsequent rvalid is ignored (not in WAIT).
//  - FSM IDLE->REQ->(WAIT)->DONE->IDLE. ex_ready=1 only in IDLE; accept on ex_valid&ex_ready,
//    latching addr, wdata, op, rd.
//  - Misaligned (H: off[0]!=0; W: off[1:0]!=0; D: off!=0; off=addr[2:0]): IDLE->DONE,
//    no dmem_req, wb_misalign=1.
//  - REQ: dmem_req=1; addr/we/wdata/wstrb stable until the gnt cycle. gnt: store->DONE,
//    load->WAIT. dmem_req drops the cycle after gnt.
//  - WAIT: on dmem_rvalid register extracted data -> DONE. rvalid in the gnt cycle is
//    illegal; rvalid in any other state is ignored.
//  - DONE: wb_valid=1, outputs stable until wb_ready; then IDLE. No overlap of ops.
//  - Latency with gnt in first REQ cycle and rvalid one cycle later: load accept at T ->
//    wb_valid at T+3; store -> T+2; misaligned -> T+1.
//  - Load extract: lane = rdata >> (8*off); take size bytes; extend with bit 7/15/31
//    unless unsigned; D ignores unsigned bit.
//  - Store: wstrb = {01,03,0F,FF}[size] << off; wdata = ex_wdata << (8*off), masked to lanes.
// STRUCTURE
//  - Shared defines header: mem_op field positions, size codes, FSM state encodings.
//  - Sub-module lsu_load_align: combinational (rdata, off, size, unsigned) -> 64b result;
//    store strobe/shift kept inline.
// TESTING
//  1 SW addr 0x80000004 wdata 0x11223344, gnt immediate -> dmem_addr 0x80000000,
//    wstrb 0xF0, wdata[63:32]=0x11223344, wb_valid at T+2, wb_rd=0.
//  2 rdata 0x0123456789ABCDEF: LB off3 -> 0xFFFFFFFFFFFFFF89; LBU off3 -> 0x89;
//    LH off6 -> 0x0123; LW off4 -> 0x01234567; LD off0 -> full word.
//  3 LW addr 0x80000002 -> no dmem_req, wb_valid at T+1, wb_misalign=1, wb_rdata=0, wb_rd=0.
//  4 gnt low 3 cycles, wb_ready low 2 cycles -> req fields stable, wb outputs held,
//    ex_ready=0 throughout; one wb handshake only.
//  5 rst_n low during WAIT -> outputs 0/ex_ready=1 asynchronously; late rvalid ignored;
//    next LD completes correctly.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the LSU memory stage: bus widths, mem_op field layout,
// access size codes, FSM states and small decode helpers.
package lsu_mem_stage_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = 3;

  localparam int OP_STORE_BIT    = 3;
  localparam int OP_UNSIGNED_BIT = 2;
  localparam int OP_SIZE_LSB     = 0;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_misaligned(mem_size_e size, logic [OFF_W-1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

  // Strobe for the access before it is shifted to its lane offset.
  function automatic logic [STRB_W-1:0] size_strobe(mem_size_e size);
    logic [STRB_W-1:0] strb;
    strb = '0;
    case (size)
      SIZE_B:  strb = 8'h01;
      SIZE_H:  strb = 8'h03;
      SIZE_W:  strb = 8'h0F;
      default: strb = 8'hFF;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// req/gnt/rvalid data bus between the LSU (master) and data memory (slave).
interface lsu_mem_stage_if;
  import lsu_mem_stage_pkg::*;

  logic              req;
  logic              gnt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed bytes out of an aligned 8-byte read word and
// sign- or zero-extends them to the full register width.
module lsu_load_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  off,
  input  mem_size_e         size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] lane;

  assign lane = rdata >> {off, 3'b000};

  always_comb begin
    result = '0;
    case (size)
      SIZE_B:  result = is_unsigned ? {56'b0, lane[7:0]}
                                    : {{56{lane[7]}}, lane[7:0]};
      SIZE_H:  result = is_unsigned ? {48'b0, lane[15:0]}
                                    : {{48{lane[15]}}, lane[15:0]};
      SIZE_W:  result = is_unsigned ? {32'b0, lane[31:0]}
                                    : {{32{lane[31]}}, lane[31:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: one load/store at a time from the ALU, issued over the
// req/gnt/rvalid bus, with the result held for writeback until accepted.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,

  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [3:0]        ex_mem_op,
  input  logic [4:0]        ex_rd,

  lsu_mem_stage_if.master   dmem,

  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_rdata,
  output logic [4:0]        wb_rd,
  output logic              wb_misalign
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              we_q, we_d;
  logic [OFF_W-1:0]  off_q, off_d;
  mem_size_e         size_q, size_d;
  logic              uns_q, uns_d;
  logic [4:0]        rd_q, rd_d;
  logic              misalign_q, misalign_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              ex_store;
  logic              ex_unsigned;
  mem_size_e         ex_size;
  logic [OFF_W-1:0]  ex_off;
  logic              ex_mis;
  logic [STRB_W-1:0] ex_strb;
  logic [DATA_W-1:0] ex_lane_mask;
  logic [DATA_W-1:0] load_data;

  assign ex_store    = ex_mem_op[OP_STORE_BIT];
  assign ex_unsigned = ex_mem_op[OP_UNSIGNED_BIT];
  assign ex_size     = mem_size_e'(ex_mem_op[OP_SIZE_LSB +: 2]);
  assign ex_off      = ex_addr[OFF_W-1:0];
  assign ex_mis      = is_misaligned(ex_size, ex_off);
  assign ex_strb     = size_strobe(ex_size) << ex_off;

  always_comb begin
    ex_lane_mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      ex_lane_mask[8*i +: 8] = {8{ex_strb[i]}};
    end
  end

  lsu_load_align u_load_align (
    .rdata       (dmem.rdata),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (load_data)
  );

  // Store lanes are built at accept time so the bus fields are plain flops
  // that stay stable for however long the grant takes.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    we_d       = we_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    misalign_d = misalign_q;
    result_d   = result_q;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          addr_d     = {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          we_d       = ex_store;
          off_d      = ex_off;
          size_d     = ex_size;
          uns_d      = ex_unsigned;
          misalign_d = ex_mis;
          result_d   = '0;
          rd_d       = (ex_store || ex_mis) ? 5'd0 : ex_rd;
          wstrb_d    = ex_store ? ex_strb : '0;
          wdata_d    = ex_store ? ((ex_wdata << {ex_off, 3'b000}) & ex_lane_mask) : '0;
          state_d    = ex_mis ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmem.gnt) begin
          state_d = we_q ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem.rvalid) begin
          result_d = load_data;
          state_d  = ST_DONE;
        end
      end
      default: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      we_q       <= 1'b0;
      off_q      <= '0;
      size_q     <= SIZE_B;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      misalign_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      we_q       <= we_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
      result_q   <= result_d;
    end
  end

  // Outputs are qualified by state so nothing stale is visible outside REQ/DONE.
  assign ex_ready    = (state_q == ST_IDLE);
  assign dmem.req    = (state_q == ST_REQ);
  assign dmem.we     = dmem.req & we_q;
  assign dmem.addr   = dmem.req ? addr_q  : '0;
  assign dmem.wdata  = dmem.req ? wdata_q : '0;
  assign dmem.wstrb  = dmem.req ? wstrb_q : '0;

  assign wb_valid    = (state_q == ST_DONE);
  assign wb_rdata    = wb_valid ? result_q : '0;
  assign wb_rd       = wb_valid ? rd_q : 5'd0;
  assign wb_misalign = wb_valid & misalign_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus randomized ops
// compared against a byte-level reference model.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_addr;
  logic [63:0] ex_wdata;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_rdata;
  logic [4:0]  wb_rd;
  logic        wb_misalign;

  int vectors     = 0;
  int miscompares = 0;

  lsu_mem_stage_if dmem_bus ();

  lsu_mem_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_mem_op   (ex_mem_op),
    .ex_rd       (ex_rd),
    .dmem        (dmem_bus),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rdata    (wb_rdata),
    .wb_rd       (wb_rd),
    .wb_misalign (wb_misalign)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: accesses are described as byte counts and byte copies.
  function automatic int refBytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic refMisaligned(input logic [63:0] addr, input logic [1:0] size);
    return (int'(addr[2:0]) % refBytes(size)) != 0;
  endfunction

  function automatic logic [7:0] refStrb(input logic [63:0] addr, input logic [1:0] size);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < refBytes(size); i++) s[int'(addr[2:0]) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] refWdata(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] data);
    logic [63:0] w;
    w = 64'h0;
    for (int i = 0; i < refBytes(size); i++) w[8*(int'(addr[2:0]) + i) +: 8] = data[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] refLoad(input logic [63:0] addr, input logic [1:0] size,
                                          input logic uns, input logic [63:0] rdata);
    logic [63:0] r;
    int n;
    n = refBytes(size);
    r = 64'h0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = rdata[8*(int'(addr[2:0]) + i) +: 8];
    if (!uns && n < 8 && r[8*n-1]) begin
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic store, input logic uns, input logic [1:0] size,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [4:0] rd, input logic [63:0] rdata,
                               input int gnt_delay, input int rv_delay, input int wb_delay,
                               output logic [63:0] got_rdata);
    logic        mis;
    logic [63:0] exp_res;
    logic [4:0]  exp_rd;
    mis     = refMisaligned(addr, size);
    exp_res = (store || mis) ? 64'h0 : refLoad(addr, size, uns, rdata);
    exp_rd  = (store || mis) ? 5'd0 : rd;
    got_rdata = 64'h0;

    @(negedge clk);
    checkOutput("ex_ready_idle", 64'(ex_ready), 64'd1);
    ex_valid  = 1'b1;
    ex_addr   = addr;
    ex_wdata  = wdata;
    ex_mem_op = {store, uns, size};
    ex_rd     = rd;
    @(negedge clk);
    ex_valid  = 1'b0;
    ex_addr   = {$urandom, $urandom};
    ex_wdata  = {$urandom, $urandom};
    ex_mem_op = 4'($urandom);
    ex_rd     = 5'($urandom);

    if (!mis) begin
      for (int k = 0; k <= gnt_delay; k++) begin
        checkOutput("req_high", 64'(dmem_bus.req), 64'd1);
        checkOutput("req_addr", dmem_bus.addr, {addr[63:3], 3'b000});
        checkOutput("req_we", 64'(dmem_bus.we), 64'(store));
        checkOutput("req_wstrb", 64'(dmem_bus.wstrb), store ? 64'(refStrb(addr, size)) : 64'h0);
        checkOutput("req_wdata", dmem_bus.wdata, store ? refWdata(addr, size, wdata) : 64'h0);
        checkOutput("ex_ready_busy", 64'(ex_ready), 64'd0);
        checkOutput("wb_early_req", 64'(wb_valid), 64'd0);
        dmem_bus.gnt = (k == gnt_delay);
        @(negedge clk);
      end
      dmem_bus.gnt = 1'b0;
      checkOutput("req_drop", 64'(dmem_bus.req), 64'd0);
      if (!store) begin
        for (int j = 0; j <= rv_delay; j++) begin
          checkOutput("wb_early_wait", 64'(wb_valid), 64'd0);
          dmem_bus.rvalid = (j == rv_delay);
          dmem_bus.rdata  = (j == rv_delay) ? rdata : {$urandom, $urandom};
          @(negedge clk);
        end
        dmem_bus.rvalid = 1'b0;
        dmem_bus.rdata  = {$urandom, $urandom};
      end
    end else begin
      checkOutput("mis_no_req", 64'(dmem_bus.req), 64'd0);
    end

    got_rdata = wb_rdata;
    for (int w = 0; w <= wb_delay; w++) begin
      checkOutput("wb_valid", 64'(wb_valid), 64'd1);
      checkOutput("wb_rdata", wb_rdata, exp_res);
      checkOutput("wb_rd", 64'(wb_rd), 64'(exp_rd));
      checkOutput("wb_misalign", 64'(wb_misalign), 64'(mis));
      checkOutput("ex_ready_done", 64'(ex_ready), 64'd0);
      checkOutput("req_in_done", 64'(dmem_bus.req), 64'd0);
      wb_ready = (w == wb_delay);
      @(negedge clk);
    end
    wb_ready = 1'b0;
    checkOutput("wb_single", 64'(wb_valid), 64'd0);
    checkOutput("ex_ready_back", 64'(ex_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] rd_word;
    logic [63:0] addr;
    logic [1:0]  size;
    int          off;

    rst_n           = 1'b0;
    ex_valid        = 1'b0;
    ex_addr         = 64'h0;
    ex_wdata        = 64'h0;
    ex_mem_op       = 4'h0;
    ex_rd           = 5'd0;
    wb_ready        = 1'b0;
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = 64'h0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ex_ready", 64'(ex_ready), 64'd1);
    checkOutput("rst_req", 64'(dmem_bus.req), 64'd0);
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_wb_rdata", wb_rdata, 64'h0);
    rst_n = 1'b1;

    $display("[TB] store word, immediate grant");
    applyStimulus(1'b1, 1'b0, 2'd2, 64'h80000004, 64'h11223344, 5'd7, 64'h0, 0, 0, 0, got);

    $display("[TB] load extraction");
    rd_word = 64'h0123456789ABCDEF;
    applyStimulus(1'b0, 1'b0, 2'd0, 64'h80000003, 64'h0, 5'd1, rd_word, 0, 0, 0, got);
    checkOutput("lb_const", got, 64'hFFFFFFFFFFFFFF89);
    applyStimulus(1'b0, 1'b1, 2'd0, 64'h80000003, 64'h0, 5'd2, rd_word, 0, 0, 0, got);
    checkOutput("lbu_const", got, 64'h89);
    applyStimulus(1'b0, 1'b0, 2'd1, 64'h80000006, 64'h0, 5'd3, rd_word, 0, 0, 0, got);
    checkOutput("lh_const", got, 64'h0123);
    applyStimulus(1'b0, 1'b0, 2'd2, 64'h80000004, 64'h0, 5'd4, rd_word, 0, 0, 0, got);
    checkOutput("lw_const", got, 64'h01234567);
    applyStimulus(1'b0, 1'b1, 2'd3, 64'h80000000, 64'h0, 5'd5, rd_word, 0, 0, 0, got);
    checkOutput("ld_const", got, rd_word);

    $display("[TB] misaligned word load");
    applyStimulus(1'b0, 1'b0, 2'd2, 64'h80000002, 64'h0, 5'd9, rd_word, 0, 0, 0, got);

    $display("[TB] grant and writeback stalls");
    applyStimulus(1'b1, 1'b0, 2'd1, 64'h80000012, 64'hCAFEBABE, 5'd3, 64'h0, 3, 0, 2, got);
    applyStimulus(1'b0, 1'b0, 2'd2, 64'h80000010, 64'h0, 5'd6, 64'h8000000112345678, 3, 2, 2, got);

    $display("[TB] reset during WAIT");
    @(negedge clk);
    ex_valid  = 1'b1;
    ex_addr   = 64'h80000020;
    ex_mem_op = 4'b0011;
    ex_rd     = 5'd12;
    @(negedge clk);
    ex_valid     = 1'b0;
    dmem_bus.gnt = 1'b1;
    @(negedge clk);
    dmem_bus.gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_ex_ready", 64'(ex_ready), 64'd1);
    checkOutput("async_req", 64'(dmem_bus.req), 64'd0);
    checkOutput("async_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("async_wb_rd", 64'(wb_rd), 64'd0);
    @(negedge clk);
    rst_n           = 1'b1;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    dmem_bus.rvalid = 1'b0;
    checkOutput("late_rvalid_wb", 64'(wb_valid), 64'd0);
    checkOutput("late_rvalid_ready", 64'(ex_ready), 64'd1);
    checkOutput("late_rvalid_req", 64'(dmem_bus.req), 64'd0);
    applyStimulus(1'b0, 1'b0, 2'd3, 64'h80000028, 64'h0, 5'd13, 64'h0F1E2D3C4B5A6978, 1, 1, 0, got);

    $display("[TB] randomized operations");
    for (int t = 0; t < 60; t++) begin
      size = 2'($urandom_range(0, 3));
      off  = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) off = off - (off % refBytes(size));
      addr      = {$urandom, $urandom};
      addr[2:0] = 3'(off);
      applyStimulus(1'($urandom), 1'($urandom), size, addr, {$urandom, $urandom},
                    5'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
